seg_scan_driver: RTL and testbench

- Multiplexed 8-digit seven-segment scan driver; sits directly downstream of the BCD digit producers (two-digit number splitter, future counters) and drives the board anodes and cathodes.
- Replaces the ad-hoc two-state anode FSM and its separate 500 Hz clock. It uses a single clock with an internal tick prescaler, anti-ghosting blanking, leading-zero suppression and tear-free frame-synchronous digit loading.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_driver_if.sv | 29 ++
 rtl/seg_decode_bcd.sv | 26 ++
 rtl/seg_scan_driver.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   - scan_state_t : two-state scan FSM encoding (blanking gap / digit shown)
//   - SEG_*        : active-low cathode patterns, bit 0 = a ... bit 6 = g
//   - idx_width()  : counter/index width helper, never narrower than one bit
package seg_pkg;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_t;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Bits needed to hold values 0..n-1 (minimum one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the BCD digit producers and the scan driver.
//   digits/dp/digit_en/lz_blank/load : producer -> driver
//   load_pending/frame_start         : driver status back to the producer
//   anodes/cathodes/dp_n             : driver -> board pins (active-low)
// master = producer side, slave = scan driver.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic                    load;
    logic                    load_pending;
    logic                    frame_start;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [6:0]              cathodes;
    logic                    dp_n;

    modport master (
        output digits, dp, digit_en, lz_blank, load,
        input  load_pending, frame_start, anodes, cathodes, dp_n
    );

    modport slave (
        input  digits, dp, digit_en, lz_blank, load,
        output load_pending, frame_start, anodes, cathodes, dp_n
    );
endinterface

// File: rtl/seg_decode_bcd.sv
// Combinational BCD to seven-segment decoder.
//   bcd  : 4-bit nibble
//   segs : active-low cathodes {g..a}; non-BCD nibbles (A-F) show a dash
module seg_decode_bcd
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segs
);
    always_comb begin
        segs = SEG_DASH;
        case (bcd)
            4'd0:    segs = SEG_0;
            4'd1:    segs = SEG_1;
            4'd2:    segs = SEG_2;
            4'd3:    segs = SEG_3;
            4'd4:    segs = SEG_4;
            4'd5:    segs = SEG_5;
            4'd6:    segs = SEG_6;
            4'd7:    segs = SEG_7;
            4'd8:    segs = SEG_8;
            4'd9:    segs = SEG_9;
            default: segs = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver.
//   clk_5MHz : system clock
//   reset    : asynchronous, active-high
//   bus      : slave side of seg_scan_driver_if (digit data in, pins out)
// Each digit owns a slot of TICK_DIV cycles: BLANK_CYCLES with all anodes
// off (anti-ghosting), then the digit is shown. New data is held in a
// pending shadow and only copied to the displayed set at the frame wrap,
// so a frame never mixes old and new digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input logic          clk_5MHz,
    input logic          reset,
    seg_scan_driver_if.slave bus
);
    localparam int IDX_W   = idx_width(NUM_DIGITS);
    localparam int PRESC_W = idx_width(TICK_DIV);
    localparam int BLANK_W = idx_width(BLANK_CYCLES);

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(TICK_DIV - 1);
    localparam logic [BLANK_W-1:0] BLANK_RELOAD = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state_reg, state_next;
    logic [PRESC_W-1:0]      presc_reg, presc_next;
    logic [BLANK_W-1:0]      blank_cnt_reg, blank_cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;

    logic [4*NUM_DIGITS-1:0] act_digits_reg, act_digits_next;
    logic [NUM_DIGITS-1:0]   act_dp_reg, act_dp_next;
    logic [NUM_DIGITS-1:0]   act_en_reg, act_en_next;
    logic [4*NUM_DIGITS-1:0] pend_digits_reg, pend_digits_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic [NUM_DIGITS-1:0]   pend_en_reg, pend_en_next;
    logic                    load_pending_reg, load_pending_next;

    logic                    frame_start_reg, frame_start_next;
    logic [NUM_DIGITS-1:0]   anodes_reg, anodes_next;
    logic [6:0]              cathodes_reg, cathodes_next;
    logic                    dp_n_reg, dp_n_next;

    logic                    tick;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   lz_hide;
    logic [3:0]              sel_nibble;
    logic [6:0]              sel_segs;

    assign tick       = (presc_reg == '0);
    assign frame_wrap = tick && (idx_reg == LAST_IDX);

    // Digit i (i > 0) is suppressed when it and all higher digits are zero.
    // Each bit looks at the whole upper slice directly rather than chaining.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign lz_hide[gi] = 1'b0;
            end else begin : g_upper
                assign lz_hide[gi] = bus.lz_blank &&
                    (act_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign sel_nibble = act_digits_reg[{idx_reg, 2'b00} +: 4];

    seg_decode_bcd u_decode (
        .bcd  (sel_nibble),
        .segs (sel_segs)
    );

    // Scan FSM, prescaler and blank counter: next state
    always_comb begin
        presc_next     = tick ? PRESC_RELOAD : presc_reg - 1'b1;
        state_next     = state_reg;
        blank_cnt_next = blank_cnt_reg;
        idx_next       = idx_reg;
        if (tick) begin
            // Slot boundary wins over anything the blank counter is doing
            idx_next       = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            state_next     = SCAN_BLANK;
            blank_cnt_next = BLANK_RELOAD;
        end else begin
            case (state_reg)
                SCAN_BLANK: begin
                    if (blank_cnt_reg == '0) begin
                        state_next = SCAN_SHOW;
                    end else begin
                        blank_cnt_next = blank_cnt_reg - 1'b1;
                    end
                end
                SCAN_SHOW: state_next = SCAN_SHOW;
                default:   state_next = SCAN_BLANK;
            endcase
        end
    end

    // Pin outputs follow the state being entered, so they line up with it.
    // When SHOW is entered or held, the index is unchanged this cycle.
    always_comb begin
        anodes_next      = '1;
        cathodes_next    = SEG_OFF;
        dp_n_next        = 1'b1;
        frame_start_next = frame_wrap;
        if (state_next == SCAN_SHOW) begin
            anodes_next   = ~((NUM_DIGITS'(1) << idx_reg) & act_en_reg);
            cathodes_next = lz_hide[idx_reg] ? SEG_OFF : sel_segs;
            dp_n_next     = ~act_dp_reg[idx_reg];
        end
    end

    // Shadow loading: pending data is promoted only at the frame wrap; a load
    // coinciding with the wrap bypasses the shadow and is shown immediately.
    always_comb begin
        act_digits_next   = act_digits_reg;
        act_dp_next       = act_dp_reg;
        act_en_next       = act_en_reg;
        pend_digits_next  = pend_digits_reg;
        pend_dp_next      = pend_dp_reg;
        pend_en_next      = pend_en_reg;
        load_pending_next = load_pending_reg;
        if (frame_wrap) begin
            load_pending_next = 1'b0;
            if (bus.load) begin
                act_digits_next = bus.digits;
                act_dp_next     = bus.dp;
                act_en_next     = bus.digit_en;
            end else if (load_pending_reg) begin
                act_digits_next = pend_digits_reg;
                act_dp_next     = pend_dp_reg;
                act_en_next     = pend_en_reg;
            end
        end else if (bus.load) begin
            pend_digits_next  = bus.digits;
            pend_dp_next      = bus.dp;
            pend_en_next      = bus.digit_en;
            load_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            state_reg     <= SCAN_BLANK;
            presc_reg     <= PRESC_RELOAD;
            blank_cnt_reg <= BLANK_RELOAD;
            idx_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            blank_cnt_reg <= blank_cnt_next;
            idx_reg       <= idx_next;
        end
    end

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            act_digits_reg   <= '0;
            act_dp_reg       <= '0;
            act_en_reg       <= '0;
            pend_digits_reg  <= '0;
            pend_dp_reg      <= '0;
            pend_en_reg      <= '0;
            load_pending_reg <= 1'b0;
            frame_start_reg  <= 1'b0;
            anodes_reg       <= '1;
            cathodes_reg     <= SEG_OFF;
            dp_n_reg         <= 1'b1;
        end else begin
            act_digits_reg   <= act_digits_next;
            act_dp_reg       <= act_dp_next;
            act_en_reg       <= act_en_next;
            pend_digits_reg  <= pend_digits_next;
            pend_dp_reg      <= pend_dp_next;
            pend_en_reg      <= pend_en_next;
            load_pending_reg <= load_pending_next;
            frame_start_reg  <= frame_start_next;
            anodes_reg       <= anodes_next;
            cathodes_reg     <= cathodes_next;
            dp_n_reg         <= dp_n_next;
        end
    end

    assign bus.load_pending = load_pending_reg;
    assign bus.frame_start  = frame_start_reg;
    assign bus.anodes       = anodes_reg;
    assign bus.cathodes     = cathodes_reg;
    assign bus.dp_n         = dp_n_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (TICK_DIV = 20, BLANK_CYCLES = 4).
// A frame is 8 slots x 20 cycles; cycle c of a frame counts from the cycle
// in which frame_start is high. The reference model keeps the displayed and
// pending data sets and derives every expected pin value from the slot
// number, the position in the slot and the digit rules.
module tb_seg_scan_driver;
    localparam int ND    = 8;
    localparam int TICK  = 20;
    localparam int BLANK = 4;
    localparam int FRAME = ND * TICK;

    typedef struct packed {
        logic signed [31:0] c;
        logic [31:0]        d;
        logic [7:0]         dp;
        logic [7:0]         en;
    } ld_t;

    logic clk_5MHz = 1'b0;
    logic reset;
    always #100 clk_5MHz = ~clk_5MHz;

    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TICK),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_d, p_d;
    logic [7:0]  m_dp, m_en, p_dp, p_en;
    logic        m_pend;
    logic        lz_v;

    function automatic ld_t mk_ld(input int c, input logic [31:0] d,
                                  input logic [7:0] dp, input logic [7:0] en);
        ld_t l;
        l.c  = c;
        l.d  = d;
        l.dp = dp;
        l.en = en;
        return l;
    endfunction

    // Standard seven-segment patterns, active-low {g..a}; non-BCD = dash
    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Runs one frame from its cycle 0, checking every cycle, applying up to
    // two loads and an optional lz_blank toggle at the given frame cycles.
    task automatic run_frame(input string tag, input ld_t la, input ld_t lb, input int lzc);
        int s, pos;
        logic lz_seen, hide, ld_now, exp_fs;
        logic [7:0] exp_an;
        logic [6:0] exp_cat;
        ld_t cur;
        lz_seen = lz_v;
        cur = la;
        $display("frame %s: digits=%h en=%h dp=%h lz=%0d", tag, m_d, m_en, m_dp, lz_v);
        for (int c = 0; c < FRAME; c++) begin
            s   = c / TICK;
            pos = c % TICK;
            exp_fs = (c == 0);
            n_checks++;
            if (bus.frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL %s frame_start c=%0d: got %b, expected %b", tag, c, bus.frame_start, exp_fs);
            end
            n_checks++;
            if (bus.load_pending !== m_pend) begin
                n_fail++;
                $display("FAIL %s load_pending c=%0d: got %b, expected %b", tag, c, bus.load_pending, m_pend);
            end
            if (pos < BLANK) exp_an = 8'hFF;
            else             exp_an = m_en[s] ? ~(8'h01 << s) : 8'hFF;
            n_checks++;
            if (bus.anodes !== exp_an) begin
                n_fail++;
                $display("FAIL %s anodes c=%0d: got %h, expected %h", tag, c, bus.anodes, exp_an);
            end
            if (pos >= BLANK && m_en[s]) begin
                hide    = lz_seen && (s > 0) && ((m_d >> (4 * s)) == 32'd0);
                exp_cat = hide ? 7'h7F : exp_seg(m_d[4*s +: 4]);
                n_checks++;
                if (bus.cathodes !== exp_cat) begin
                    n_fail++;
                    $display("FAIL %s cathodes c=%0d: got %b, expected %b", tag, c, bus.cathodes, exp_cat);
                end
                n_checks++;
                if (bus.dp_n !== ~m_dp[s]) begin
                    n_fail++;
                    $display("FAIL %s dp_n c=%0d: got %b, expected %b", tag, c, bus.dp_n, ~m_dp[s]);
                end
            end
            // Stimulus for this cycle
            if (c == lzc) lz_v = ~lz_v;
            bus.lz_blank = lz_v;
            ld_now = 1'b0;
            if (c == la.c) begin
                cur = la; ld_now = 1'b1;
            end else if (c == lb.c) begin
                cur = lb; ld_now = 1'b1;
            end
            if (ld_now) begin
                bus.load = 1'b1; bus.digits = cur.d; bus.dp = cur.dp; bus.digit_en = cur.en;
                if (c == FRAME - 1) begin
                    m_d = cur.d; m_dp = cur.dp; m_en = cur.en; m_pend = 1'b0;
                end else begin
                    p_d = cur.d; p_dp = cur.dp; p_en = cur.en; m_pend = 1'b1;
                end
            end else begin
                // Junk on the data lines must never be captured without load
                bus.load = 1'b0; bus.digits = $urandom;
                bus.dp = 8'($urandom); bus.digit_en = 8'($urandom);
            end
            lz_seen = lz_v;
            @(negedge clk_5MHz);
        end
        bus.load = 1'b0;
        if (m_pend) begin
            m_d = p_d; m_dp = p_dp; m_en = p_en; m_pend = 1'b0;
        end
    endtask

    // After reset release: dark display, no pending load, frame_start only
    // after 8 full slots of 20 cycles.
    task automatic run_after_release(input string tag);
        logic exp_fs;
        m_d = '0; m_dp = '0; m_en = '0; m_pend = 1'b0;
        p_d = '0; p_dp = '0; p_en = '0;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk_5MHz);
            exp_fs = (i == FRAME);
            n_checks++;
            if (bus.frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL %s frame_start cycle %0d: got %b, expected %b", tag, i, bus.frame_start, exp_fs);
            end
            n_checks++;
            if (bus.anodes !== 8'hFF || bus.load_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dark cycle %0d: got anodes %h pending %b, expected ff 0", tag, i, bus.anodes, bus.load_pending);
            end
        end
        $display("release %s: first frame_start checked at cycle %0d", tag, FRAME);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load = 1'b0; bus.digits = '0; bus.dp = '0; bus.digit_en = '0;
        lz_v = 1'b0; bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk_5MHz);
        n_checks++;
        if (bus.anodes !== 8'hFF) begin
            n_fail++; $display("FAIL reset anodes: got %h, expected ff", bus.anodes);
        end
        n_checks++;
        if (bus.cathodes !== 7'h7F) begin
            n_fail++; $display("FAIL reset cathodes: got %h, expected 7f", bus.cathodes);
        end
        n_checks++;
        if (bus.dp_n !== 1'b1 || bus.frame_start !== 1'b0 || bus.load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: got dp_n %b fs %b pend %b, expected 1 0 0", bus.dp_n, bus.frame_start, bus.load_pending);
        end
        reset = 1'b0;
        run_after_release("reset");
    endtask

    task automatic test_basic();
        lz_v = 1'b0;
        run_frame("basic-load", mk_ld(5, 32'h0000_0042, 8'h00, 8'h03), mk_ld(-1, 0, 0, 0), -1);
        run_frame("basic-show", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
    endtask

    task automatic test_leading_zero();
        lz_v = 1'b1;
        run_frame("lz-load", mk_ld(5, 32'h0000_0042, 8'h00, 8'hFF), mk_ld(-1, 0, 0, 0), -1);
        run_frame("lz-on", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
        run_frame("lz-clear", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), 10);
    endtask

    task automatic test_dash_dp();
        run_frame("dash-load", mk_ld(7, 32'h0000_B042, 8'h08, 8'hFF), mk_ld(-1, 0, 0, 0), -1);
        run_frame("dash-show", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
    endtask

    task automatic test_tear_free();
        run_frame("tear-load", mk_ld(3 * TICK + 5, 32'h1234_5678, 8'h00, 8'hFF), mk_ld(-1, 0, 0, 0), -1);
        run_frame("tear-show", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
    endtask

    task automatic test_back_to_back();
        run_frame("double-load", mk_ld(30, 32'h5555_0000, 8'hF0, 8'h0F),
                  mk_ld(100, 32'h9876_5432, 8'h81, 8'hFF), -1);
        run_frame("double-show", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
    endtask

    task automatic test_wrap_load();
        run_frame("wrap-load", mk_ld(FRAME - 1, 32'h2468_1357, 8'h3C, 8'hA5), mk_ld(-1, 0, 0, 0), -1);
        run_frame("wrap-show", mk_ld(-1, 0, 0, 0), mk_ld(-1, 0, 0, 0), -1);
    endtask

    task automatic test_random();
        ld_t l;
        logic [31:0] d;
        int lzc;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            d = d >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) l = mk_ld(-1, 0, 0, 0);
            else l = mk_ld(int'($urandom_range(0, FRAME - 1)), d, 8'($urandom), 8'($urandom));
            lzc = int'($urandom_range(1, FRAME - 1));
            run_frame("random", l, mk_ld(-1, 0, 0, 0), lzc);
        end
    endtask

    task automatic test_async_reset();
        lz_v = 1'b0;
        bus.lz_blank = 1'b0;
        run_frame("arst-load", mk_ld(5, 32'h8765_4321, 8'h00, 8'hFF), mk_ld(-1, 0, 0, 0), -1);
        // Cycle 0 of a frame showing the data above; start a pending load
        repeat (2) @(negedge clk_5MHz);
        bus.load = 1'b1; bus.digits = 32'h1111_1111; bus.dp = 8'hFF; bus.digit_en = 8'hFF;
        @(negedge clk_5MHz);
        bus.load = 1'b0;
        n_checks++;
        if (bus.load_pending !== 1'b1) begin
            n_fail++; $display("FAIL arst pending-before: got %b, expected 1", bus.load_pending);
        end
        repeat (9) @(negedge clk_5MHz);
        n_checks++;
        if (bus.anodes !== 8'hFE) begin
            n_fail++; $display("FAIL arst show-before: got anodes %h, expected fe", bus.anodes);
        end
        #20 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.anodes !== 8'hFF) begin
            n_fail++; $display("FAIL arst anodes: got %h, expected ff", bus.anodes);
        end
        n_checks++;
        if (bus.cathodes !== 7'h7F) begin
            n_fail++; $display("FAIL arst cathodes: got %h, expected 7f", bus.cathodes);
        end
        n_checks++;
        if (bus.dp_n !== 1'b1 || bus.load_pending !== 1'b0) begin
            n_fail++; $display("FAIL arst flags: got dp_n %b pend %b, expected 1 0", bus.dp_n, bus.load_pending);
        end
        @(negedge clk_5MHz);
        reset = 1'b0;
        run_after_release("async-reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zero();
        test_dash_dp();
        test_tear_free();
        test_back_to_back();
        test_wrap_load();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(200 * 20000);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
